reorder_buffer: RTL and testbench

- Circular reorder buffer on the far side of dispatch's ROB allocation interface.
- Accepts one allocation per cycle and returns the tag the allocation receives, plus a full flag.
- Records completions from the ALU, branch and LSU units.
- Retires in program order at one instruction per cycle, sending pd_old to the free list.
- Rolls back younger entries on a branch mispredict.

---
 rtl/reorder_buffer.sv | 163 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB between dispatch allocation and in-order retire.
// One allocation and one retire per cycle, three completion ports (ALU, branch,
// LSU), and rollback of younger entries on a branch mispredict.
// Optional statistics counters are compiled in with `define ROB_STATS_EN.
module reorder_buffer #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [6:0]       pd_new_in,
    input  logic [6:0]       pd_old_in,
    input  logic [31:0]      pc_in,
    output logic [PTR_W-1:0] ptr,
    output logic             full,
    output logic             empty,
    input  logic             fu_alu_done,
    input  logic [PTR_W-1:0] rob_fu_alu,
    input  logic             fu_b_done,
    input  logic [PTR_W-1:0] rob_fu_b,
    input  logic             fu_mem_done,
    input  logic [PTR_W-1:0] rob_fu_mem,
    input  logic             br_mispredict,
    input  logic [PTR_W-1:0] mispredict_tag,
    output logic             valid_retired,
    output logic [PTR_W-1:0] rob_tag_out,
    output logic [6:0]       pd_old_out,
    output logic [6:0]       pd_new_out,
    output logic [31:0]      pc_out
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]      retired_count,
    output logic [31:0]      flush_count
`endif
);

    typedef struct packed {
        logic [6:0]  pd_new;
        logic [6:0]  pd_old;
        logic [31:0] pc;
    } rob_payload_t;

    rob_payload_t     payload [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] complete;
    logic [DEPTH-1:0] done_hit;
    logic [DEPTH-1:0] squash;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             alloc;
    logic             retire;
    logic             flush;
    logic [PTR_W-1:0] br_age;

    assign ptr    = tail;
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    // Any mispredict, even one with a stale tag, blocks the allocation.
    assign alloc  = write_en && !full && !br_mispredict;
    assign retire = valid[head] && complete[head];
    assign flush  = br_mispredict && valid[mispredict_tag];
    // Age relative to head; DEPTH is a power of two so the subtract wraps.
    assign br_age = mispredict_tag - head;

    // Per-entry completion match and squash decision.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] age;
        assign age = PTR_W'(i) - head;
        assign done_hit[i] = (fu_alu_done && rob_fu_alu == PTR_W'(i)) ||
                             (fu_b_done   && rob_fu_b   == PTR_W'(i)) ||
                             (fu_mem_done && rob_fu_mem == PTR_W'(i));
        assign squash[i]   = flush && valid[i] && (age > br_age);
    end

    // Entry status: allocate, squash/retire clear, completion set (only on valid entries).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            complete <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && tail == PTR_W'(i)) begin
                    valid[i]    <= 1'b1;
                    complete[i] <= 1'b0;
                end else if (squash[i] || (retire && head == PTR_W'(i))) begin
                    valid[i]    <= 1'b0;
                    complete[i] <= 1'b0;
                end else if (valid[i] && done_hit[i]) begin
                    complete[i] <= 1'b1;
                end
            end
        end
    end

    // Payload storage; qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            payload[tail] <= '{pd_new: pd_new_in, pd_old: pd_old_in, pc: pc_in};
        end
    end

    // Head, tail and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) head <= head + PTR_W'(1);
            if (flush) begin
                tail  <= mispredict_tag + PTR_W'(1);
                count <= {1'b0, br_age} + (PTR_W+1)'(1) - {{PTR_W{1'b0}}, retire};
            end else begin
                if (alloc) tail <= tail + PTR_W'(1);
                case ({alloc, retire})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Registered retire port; data holds between retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_retired <= 1'b0;
            rob_tag_out   <= '0;
            pd_old_out    <= '0;
            pd_new_out    <= '0;
            pc_out        <= '0;
        end else begin
            valid_retired <= retire;
            if (retire) begin
                rob_tag_out <= head;
                pd_old_out  <= payload[head].pd_old;
                pd_new_out  <= payload[head].pd_new;
                pc_out      <= payload[head].pc;
            end
        end
    end

`ifdef ROB_STATS_EN
    // Valid entries younger than the branch, taken before this cycle's update.
    logic [PTR_W:0] squash_n;
    assign squash_n = count - {1'b0, br_age} - (PTR_W+1)'(1);

    // Retire counter saturates; flush counter accumulates squashed entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
            flush_count   <= '0;
        end else begin
            if (retire && retired_count != '1) retired_count <= retired_count + 32'd1;
            if (flush) flush_count <= flush_count + 32'(squash_n);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scoreboard bench for reorder_buffer.
module tb_reorder_buffer;
    localparam int D = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [6:0]  pd_new_in = '0, pd_old_in = '0;
    logic [31:0] pc_in = '0;
    logic [4:0]  ptr;
    logic        full, empty;
    logic        fu_alu_done = 1'b0, fu_b_done = 1'b0, fu_mem_done = 1'b0;
    logic [4:0]  rob_fu_alu = '0, rob_fu_b = '0, rob_fu_mem = '0;
    logic        br_mispredict = 1'b0;
    logic [4:0]  mispredict_tag = '0;
    logic        valid_retired;
    logic [4:0]  rob_tag_out;
    logic [6:0]  pd_old_out, pd_new_out;
    logic [31:0] pc_out;
`ifdef ROB_STATS_EN
    logic [31:0] retired_count, flush_count;
`endif

    reorder_buffer #(.DEPTH(D), .PTR_W(5)) dut (
        .clk(clk), .reset(reset), .write_en(write_en),
        .pd_new_in(pd_new_in), .pd_old_in(pd_old_in), .pc_in(pc_in),
        .ptr(ptr), .full(full), .empty(empty),
        .fu_alu_done(fu_alu_done), .rob_fu_alu(rob_fu_alu),
        .fu_b_done(fu_b_done), .rob_fu_b(rob_fu_b),
        .fu_mem_done(fu_mem_done), .rob_fu_mem(rob_fu_mem),
        .br_mispredict(br_mispredict), .mispredict_tag(mispredict_tag),
        .valid_retired(valid_retired), .rob_tag_out(rob_tag_out),
        .pd_old_out(pd_old_out), .pd_new_out(pd_new_out), .pc_out(pc_out)
`ifdef ROB_STATS_EN
        , .retired_count(retired_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  tag;
        logic [6:0]  pdo;
        logic [6:0]  pdn;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_fail = 0, n_ret = 0, m_tail = 0, r0 = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Retire monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (valid_retired === 1'b1) begin
            n_ret++;
            n_cmp++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_retire: observed tag %0d expected no retire", rob_tag_out);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("ret_tag", rob_tag_out, e.tag);
                chk("ret_pd_old", pd_old_out, e.pdo);
                chk("ret_pd_new", pd_new_out, e.pdn);
                chk("ret_pc", pc_out, e.pc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_en = 0; br_mispredict = 0;
        fu_alu_done = 0; fu_b_done = 0; fu_mem_done = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        q.delete();
        m_tail = 0;
        step(); step();
        reset = 0;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic [6:0] pdn, input logic [6:0] pdo);
        exp_t e;
        write_en = 1; pc_in = pc; pd_new_in = pdn; pd_old_in = pdo;
        e.tag = 5'(m_tail); e.pdo = pdo; e.pdn = pdn; e.pc = pc;
        q.push_back(e);
        m_tail = (m_tail + 1) % D;
        step();
        write_en = 0;
    endtask

    task automatic comp(input int unit, input logic [4:0] tag);
        case (unit)
            0: begin fu_alu_done = 1; rob_fu_alu = tag; end
            1: begin fu_b_done   = 1; rob_fu_b   = tag; end
            default: begin fu_mem_done = 1; rob_fu_mem = tag; end
        endcase
        step();
        idle();
    endtask

    task automatic mispredict(input logic [4:0] tag, input int squashed);
        br_mispredict = 1; mispredict_tag = tag;
        write_en = 1; pc_in = 32'hDEAD; pd_new_in = 7'd127; pd_old_in = 7'd126;
        step();
        idle();
        m_tail = (int'(tag) + 1) % D;
        repeat (squashed) void'(q.pop_back());
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ptr", ptr, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid_retired", valid_retired, 0);
        chk("rst_pd_old_out", pd_old_out, 0);
        chk("rst_pc_out", pc_out, 0);

        // Three allocations, out-of-order completion, in-order retire
        for (int i = 0; i < 3; i++) begin
            alloc(32'h100 + 32'(4 * i), 7'(20 + i), 7'(10 + i));
            chk("alloc_ptr", ptr, i + 1);
        end
        chk("alloc_empty", empty, 0);
        r0 = n_ret;
        comp(0, 5'd2);
        comp(1, 5'd0);
        chk("no_retire_before_edge", valid_retired, 0);
        comp(2, 5'd1);
        chk("tag0_retired", valid_retired, 1);
        repeat (4) step();
        chk("retire_pulses_3", n_ret - r0, 3);
        chk("drained_empty", empty, 1);
        chk("queue_drained_1", q.size(), 0);

        // Fill to full, ignored 33rd write, retire + allocate with wrap
        do_reset();
        for (int i = 0; i < D; i++) alloc(32'h200 + 32'(4 * i), 7'(i), 7'(i + 64));
        chk("full_set", full, 1);
        chk("full_ptr_wrap", ptr, 0);
        write_en = 1; pc_in = 32'hBAD; step(); idle();
        chk("ignored_ptr", ptr, 0);
        chk("ignored_full", full, 1);
        r0 = n_ret;
        fu_alu_done = 1; rob_fu_alu = 5'd0;
        fu_b_done = 1; rob_fu_b = 5'd1;
        step(); idle();
        step();
        chk("after_retire_not_full", full, 0);
        alloc(32'h300, 7'd100, 7'd101);
        chk("retire_alloc_ptr", ptr, 1);
        chk("retire_alloc_count_kept", full, 0);
        alloc(32'h304, 7'd102, 7'd103);
        chk("refull", full, 1);
        chk("refull_ptr", ptr, 2);
        chk("two_retired", n_ret - r0, 2);

        // Mispredict at tag 3 with concurrent write_en
        do_reset();
        for (int i = 0; i < 8; i++) alloc(32'h400 + 32'(4 * i), 7'(40 + i), 7'(50 + i));
        comp(0, 5'd5);
        comp(1, 5'd7);
        r0 = n_ret;
        mispredict(5'd3, 4);
        chk("mp_ptr", ptr, 4);
        chk("mp_full", full, 0);
        chk("mp_empty", empty, 0);
        comp(0, 5'd6);
        chk("stale_done_no_retire", valid_retired, 0);
        alloc(32'h500, 7'd60, 7'd61);
        chk("mp_next_tag", ptr, 5);
        fu_alu_done = 1; rob_fu_alu = 5'd0;
        fu_b_done = 1; rob_fu_b = 5'd0;
        fu_mem_done = 1; rob_fu_mem = 5'd0;
        step(); idle();
        for (int t = 1; t < 5; t++) comp(t % 3, 5'(t));
        repeat (4) step();
        chk("mp_retired_5", n_ret - r0, 5);
        chk("mp_empty_after", empty, 1);
        chk("queue_drained_3", q.size(), 0);

        // Wrapped window: head 30, tail 2, mispredict at 31
        do_reset();
        for (int i = 0; i < 30; i++) alloc(32'h600 + 32'(4 * i), 7'(i), 7'(i + 1));
        for (int i = 0; i < 30; i++) comp(i % 3, 5'(i));
        repeat (3) step();
        chk("wrap_pre_empty", empty, 1);
        chk("wrap_pre_ptr", ptr, 30);
        for (int i = 0; i < 4; i++) alloc(32'h700 + 32'(4 * i), 7'(90 + i), 7'(110 + i));
        chk("wrap_ptr_2", ptr, 2);
        mispredict(5'd31, 2);
        chk("wrap_mp_ptr", ptr, 0);
        chk("wrap_mp_empty", empty, 0);
`ifdef ROB_STATS_EN
        chk("stats_flush", flush_count, 2);
        chk("stats_retired", retired_count, 30);
`endif
        r0 = n_ret;
        comp(0, 5'd30);
        comp(1, 5'd31);
        repeat (2) step();
        chk("wrap_retired_2", n_ret - r0, 2);
        chk("wrap_count2_empty", empty, 1);
        chk("queue_drained_4", q.size(), 0);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'h800 + 32'(4 * i), 7'(70 + i), 7'(80 + i));
        fu_alu_done = 1; rob_fu_alu = 5'd0;
        fu_b_done = 1; rob_fu_b = 5'd1;
        fu_mem_done = 1; rob_fu_mem = 5'd2;
        step(); idle();
        fu_alu_done = 1; rob_fu_alu = 5'd3;
        fu_b_done = 1; rob_fu_b = 5'd4;
        step(); idle();
        chk("pre_reset_retire", valid_retired, 1);
        chk("pre_reset_pd_old", pd_old_out, 80);
        #2 reset = 1;
        q.delete();
        #1;
        chk("async_valid_retired", valid_retired, 0);
        chk("async_pd_old_out", pd_old_out, 0);
        chk("async_pc_out", pc_out, 0);
        chk("async_ptr", ptr, 0);
        chk("async_empty", empty, 1);
        step();
        reset = 0;
        m_tail = 0;
        r0 = n_ret;
        repeat (6) step();
        chk("no_retire_after_reset", n_ret - r0, 0);
        chk("post_reset_empty", empty, 1);
        chk("post_reset_ptr", ptr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
